// File: rtl/sem_req_pkg.sv
// Shared definitions for the semaphore requester slice.
// Holds the command/status encodings, the requester FSM state type, the
// default timing parameters, and the width helpers that the requester and
// its poll timer both use.
package sem_req_pkg;

  // Command opcodes as seen on cmd_op
  localparam logic OP_POST = 1'b0;
  localparam logic OP_WAIT = 1'b1;

  // Completion status as seen on rsp_status
  localparam logic ST_OK   = 1'b0;
  localparam logic ST_FAIL = 1'b1;

  // Default timing/width parameters
  localparam int DEF_SETTLE    = 2;
  localparam int DEF_POLL_WIN  = 4;
  localparam int DEF_MAX_RETRY = 2;
  localparam int DEF_CNT_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STROBE = 3'd1,
    S_SETTLE = 3'd2,
    S_POLL   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  // Larger of two integers, used to size the shared settle/window counter
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of the retry counter; a zero-retry build still gets one bit
  function automatic int retry_w(input int max_retry);
    return (max_retry > 0) ? $clog2(max_retry + 1) : 1;
  endfunction

endpackage

// File: rtl/semaphore_requester_if.sv
// Bundle of the sequencer command/response handshake and the semaphore
// strobe/ready port.
//   master : the requester (drives strobes, enables and responses)
//   slave  : the far side (sequencer plus semaphore) seen as one peer
interface semaphore_requester_if #(
  parameter int CNT_W = 8
) ();
  logic             cmd_valid;
  logic             cmd_op;
  logic             cmd_ready;
  logic             rsp_valid;
  logic             rsp_status;
  logic [CNT_W-1:0] rsp_cycles;
  logic             WR;
  logic             WR_EN;
  logic             WR_RDY;
  logic             RD;
  logic             RD_Release;
  logic             RD_EN;
  logic             RD_RDY;

  modport master (
    input  cmd_valid, cmd_op, WR_RDY, RD_RDY,
    output cmd_ready, rsp_valid, rsp_status, rsp_cycles,
           WR, WR_EN, RD, RD_Release, RD_EN
  );

  modport slave (
    output cmd_valid, cmd_op, WR_RDY, RD_RDY,
    input  cmd_ready, rsp_valid, rsp_status, rsp_cycles,
           WR, WR_EN, RD, RD_Release, RD_EN
  );
endinterface

// File: rtl/sem_poll_timer.sv
// Settle/poll-window down-counter plus retry counter for the requester.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   load             strobe cycle: arm the settle phase (SETTLE cycles)
//   tick             advance while settling or polling
//   retry_clr        clear the retry count (new command accepted)
//   retry_inc        count one re-strobe
//   settle_done      last settle cycle
//   win_expired      last poll-window cycle
//   retries_left     re-strobes still permitted
module sem_poll_timer
  import sem_req_pkg::*;
#(
  parameter int SETTLE    = DEF_SETTLE,
  parameter int POLL_WIN  = DEF_POLL_WIN,
  parameter int MAX_RETRY = DEF_MAX_RETRY,
  localparam int TW = $clog2(max2(SETTLE, POLL_WIN) + 1),
  localparam int RW = retry_w(MAX_RETRY)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          tick,
  input  logic          retry_clr,
  input  logic          retry_inc,
  output logic          settle_done,
  output logic          win_expired,
  output logic [RW-1:0] retries_left
);

  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE - 1);
  localparam logic [TW-1:0] WIN_LD    = TW'(POLL_WIN - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [TW-1:0] T_ZERO    = {TW{1'b0}};
  localparam logic [TW-1:0] T_ONE     = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] R_ONE     = {{(RW-1){1'b0}}, 1'b1};

  logic [TW-1:0] cnt_r;
  logic          in_win_r;
  logic [RW-1:0] retry_r;

  // One counter serves both phases: when settling reaches zero it reloads
  // with the poll window; at the end of the window it parks at zero until
  // the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= T_ZERO;
      in_win_r <= 1'b0;
    end else if (load) begin
      cnt_r    <= SETTLE_LD;
      in_win_r <= 1'b0;
    end else if (tick) begin
      if (cnt_r != T_ZERO) begin
        cnt_r <= cnt_r - T_ONE;
      end else if (!in_win_r) begin
        cnt_r    <= WIN_LD;
        in_win_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Retry counter: cleared per command, saturates at MAX_RETRY
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_r <= {RW{1'b0}};
    end else if (retry_clr) begin
      retry_r <= {RW{1'b0}};
    end else if (retry_inc && (retry_r != RETRY_MAX)) begin
      retry_r <= retry_r + R_ONE;
    end else begin
      retry_r <= retry_r;
    end
  end

  assign settle_done  = !in_win_r && (cnt_r == T_ZERO);
  assign win_expired  =  in_win_r && (cnt_r == T_ZERO);
  assign retries_left = RETRY_MAX - retry_r;

endmodule

// File: rtl/semaphore_requester.sv
// Core-side initiator for a semaphored bit memory.
// Accepts POST (write) / WAIT (read-consume) commands, strobes the matching
// semaphore port, ignores RDY for SETTLE cycles, polls RDY for POLL_WIN
// cycles, re-strobes up to MAX_RETRY times and reports OK/FAIL together
// with the saturating number of cycles from acceptance to response.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        semaphore_requester_if.master: cmd_valid/cmd_op/cmd_ready,
//              rsp_valid/rsp_status/rsp_cycles, WR/WR_EN/WR_RDY,
//              RD/RD_Release/RD_EN/RD_RDY
// All outputs are registered; each is computed from the next state.
module semaphore_requester
  import sem_req_pkg::*;
#(
  parameter int SETTLE    = DEF_SETTLE,
  parameter int POLL_WIN  = DEF_POLL_WIN,
  parameter int MAX_RETRY = DEF_MAX_RETRY,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  semaphore_requester_if.master  bus
);

  localparam int RW = retry_w(MAX_RETRY);
  localparam logic [CNT_W-1:0] CYC_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CYC_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic             op_r, op_s;
  logic [CNT_W-1:0] cyc_r, cyc_inc_s;
  logic             accept_s, fail_s, rdy_s, busy_s;
  logic             load_s, tick_s, retry_clr_s, retry_inc_s;
  logic             settle_done_s, win_expired_s;
  logic [RW-1:0]    retries_left_s;

  logic             wr_r, wr_en_r, rd_r, rd_rel_r, rd_en_r;
  logic             cmd_ready_r, rsp_valid_r, rsp_status_r;
  logic [CNT_W-1:0] rsp_cycles_r;

  sem_poll_timer #(
    .SETTLE    (SETTLE),
    .POLL_WIN  (POLL_WIN),
    .MAX_RETRY (MAX_RETRY)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .load         (load_s),
    .tick         (tick_s),
    .retry_clr    (retry_clr_s),
    .retry_inc    (retry_inc_s),
    .settle_done  (settle_done_s),
    .win_expired  (win_expired_s),
    .retries_left (retries_left_s)
  );

  // Each RDY is gated by its own registered enable, so a floating or unknown
  // RDY on the idle port cannot reach the state logic.
  assign rdy_s     = (wr_en_r & bus.WR_RDY) | (rd_en_r & bus.RD_RDY);
  assign accept_s  = (state_r == S_IDLE) && bus.cmd_valid;
  assign op_s      = (state_r == S_IDLE) ? bus.cmd_op : op_r;
  assign cyc_inc_s = (cyc_r == CYC_MAX) ? cyc_r : (cyc_r + CYC_ONE);
  assign busy_s    = (state_s == S_STROBE) || (state_s == S_SETTLE) ||
                     (state_s == S_POLL);

  // Next-state and timer control
  always_comb begin
    state_s     = state_r;
    load_s      = 1'b0;
    tick_s      = 1'b0;
    retry_clr_s = 1'b0;
    retry_inc_s = 1'b0;
    fail_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          state_s     = S_STROBE;
          retry_clr_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_STROBE: begin
        load_s  = 1'b1;
        state_s = S_SETTLE;
      end
      S_SETTLE: begin
        tick_s = 1'b1;
        if (settle_done_s) begin
          state_s = S_POLL;
        end else begin
          state_s = S_SETTLE;
        end
      end
      S_POLL: begin
        tick_s = 1'b1;
        if (rdy_s) begin
          state_s = S_RESP;
        end else if (win_expired_s) begin
          if (retries_left_s != {RW{1'b0}}) begin
            retry_inc_s = 1'b1;
            state_s     = S_STROBE;
          end else begin
            fail_s  = 1'b1;
            state_s = S_RESP;
          end
        end else begin
          state_s = S_POLL;
        end
      end
      S_RESP: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, latched op, cycle counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      op_r         <= OP_POST;
      cyc_r        <= {CNT_W{1'b0}};
      wr_r         <= 1'b0;
      wr_en_r      <= 1'b0;
      rd_r         <= 1'b0;
      rd_rel_r     <= 1'b0;
      rd_en_r      <= 1'b0;
      cmd_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_status_r <= ST_OK;
      rsp_cycles_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      // Counts 1 in the strobe cycle, so the response cycle holds the total
      if (accept_s) begin
        cyc_r <= CYC_ONE;
      end else if (state_r != S_IDLE) begin
        cyc_r <= cyc_inc_s;
      end else begin
        cyc_r <= cyc_r;
      end
      wr_r         <= (state_s == S_STROBE) && (op_s == OP_POST);
      wr_en_r      <= busy_s && (op_s == OP_POST);
      rd_r         <= (state_s == S_STROBE) && (op_s == OP_WAIT);
      rd_rel_r     <= (state_s == S_STROBE) && (op_s == OP_WAIT);
      rd_en_r      <= busy_s && (op_s == OP_WAIT);
      cmd_ready_r  <= (state_s == S_IDLE);
      rsp_valid_r  <= (state_s == S_RESP);
      rsp_status_r <= ((state_s == S_RESP) && fail_s) ? ST_FAIL : ST_OK;
      rsp_cycles_r <= (state_s == S_RESP) ? cyc_inc_s : {CNT_W{1'b0}};
    end
  end

  assign bus.WR         = wr_r;
  assign bus.WR_EN      = wr_en_r;
  assign bus.RD         = rd_r;
  assign bus.RD_Release = rd_rel_r;
  assign bus.RD_EN      = rd_en_r;
  assign bus.cmd_ready  = cmd_ready_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_status = rsp_status_r;
  assign bus.rsp_cycles = rsp_cycles_r;

endmodule
